seq_pattern_tx: RTL and testbench
=================================

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 SHALL have parameter PAT_W, default 8, maximum pattern length in bits.
REQ-002 SHALL have parameter CNT_W, default 4, width of the repeat and gap count fields.
REQ-003 SHALL have port clk, input, 1, sole clock, rising-edge active.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, request to transmit, qualified by ready.
REQ-006 SHALL have port stop, input, 1, abort the current transmission.
REQ-007 SHALL have port pattern, input, PAT_W, bits to send, MSB-first from bit len-1.
REQ-008 SHALL have port len, input, $clog2(PAT_W+1), bits per pattern; 0 means PAT_W.
REQ-009 SHALL have port reps, input, CNT_W, number of repetitions; 0 means continuous until stop.
REQ-010 SHALL have port gap, input, CNT_W, idle cycles inserted between repetitions.
REQ-011 SHALL have port ready, output, 1, high when idle and able to accept start.
REQ-012 SHALL have port dout, output, 1, registered serial data, 0 when not valid.
REQ-013 SHALL have port valid, output, 1, high in every cycle where dout carries a pattern bit.
REQ-014 SHALL have port done, output, 1, one-cycle pulse on the last bit of the last repetition.

Function
REQ-015 SHALL implement states IDLE, SEND and GAP.
REQ-016 SHALL accept start only in IDLE on an edge where start=1, ready=1 and stop=0, latching pattern, len, reps and gap.
REQ-017 SHALL present the first bit on dout with valid=1 in the cycle immediately after acceptance (1-cycle latency), holding each bit for one cycle.
REQ-018 SHALL emit bits pattern[len-1] down to pattern[0] with no bubbles within a repetition.
REQ-019 SHALL go SEND->GAP after the last bit when repetitions remain and the latched gap>0, holding dout=0 and valid=0 for exactly gap cycles before re-entering SEND.
REQ-020 SHALL go SEND->SEND directly when repetitions remain and gap=0, so the next repetition's first bit follows the previous last bit back-to-back.
REQ-021 SHALL assert done coincident with the last valid bit of the final repetition and never when reps=0.
REQ-022 SHALL return to IDLE after the final bit, with ready=1 in the following cycle; a start in that cycle SHALL be accepted.
REQ-023 SHALL ignore start while not in IDLE; latched fields SHALL NOT change mid-transmission.
REQ-024 SHALL, on stop=1 sampled in SEND or GAP, enter IDLE at that edge with dout=0, valid=0, done=0 from the next cycle.
REQ-025 SHALL give stop priority over start when both are high in IDLE; start is then not accepted.
REQ-026 SHALL treat len>PAT_W as PAT_W.

Reset
REQ-027 SHALL, while reset=0, force state IDLE, ready=1, dout=0, valid=0, done=0, clearing all counters, independent of clk.
REQ-028 SHALL release reset synchronously with respect to state updates; the first acceptance occurs no earlier than the first rising edge with reset=1.
REQ-029 SHALL abort any transmission when reset is asserted mid-operation, with no done pulse.

Configuration
REQ-030 SHALL, with SEQ_PATTERN_TX_MARK_EN defined, add output mark (1 bit) pulsing with the last bit of every repetition, including under reps=0.
REQ-031 SHALL, without SEQ_PATTERN_TX_MARK_EN, omit the mark port and logic entirely, leaving all other behaviour identical.

Structure
REQ-032 SHALL place the state enumeration (IDLE, SEND, GAP) and the default PAT_W/CNT_W constants in the shared package seq_pkg.
REQ-033 SHALL implement the bit shifter and bit counter in one sub-module seq_shift_core (load, shift enable, serial out, last-bit flag), with the FSM and repeat/gap counters in the top.

Verification
REQ-034 SHALL cover: pattern=8'h0A, len=4, reps=1, gap=0 -> dout 1,0,1,0 with valid on cycles 1-4 after acceptance, done on cycle 4, ready on cycle 5.
REQ-035 SHALL cover: pattern=8'h0A, len=4, reps=2, gap=2 -> 1010, 2 cycles valid=0, 1010, then a single done.
REQ-036 SHALL cover: len=0, pattern=8'hA5, reps=1 -> 8 bits 1,0,1,0,0,1,0,1.
REQ-037 SHALL cover: reps=0, pattern 1010, stop asserted after 10 valid bits -> valid=0 the next cycle, no done, ready=1.
REQ-038 SHALL cover: reset driven low mid-SEND between clock edges -> outputs go to reset values immediately, and a later start transmits cleanly.
REQ-039 SHALL cover: loopback of dout into the team's 1010 sequence detector with pattern 1010, reps=3, gap=1 -> detector output pulses exactly 3 times.

Source files
------------

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state enumeration and default widths for the pattern transmitter
package seq_pkg;

  localparam int PAT_W_DEF = 8;
  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// rtl/seq_pattern_tx_if.sv - request/stream bundle for seq_pattern_tx
// SEQ_PATTERN_TX_MARK_EN adds the per-repetition mark output.
interface seq_pattern_tx_if
  import seq_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) ();

  logic                       start;
  logic                       stop;
  logic [PAT_W-1:0]           pattern;
  logic [$clog2(PAT_W+1)-1:0] len;
  logic [CNT_W-1:0]           reps;
  logic [CNT_W-1:0]           gap;
  logic                       ready;
  logic                       dout;
  logic                       valid;
  logic                       done;
`ifdef SEQ_PATTERN_TX_MARK_EN
  logic                       mark;
`endif

  modport master (
    output start, stop, pattern, len, reps, gap,
    input  ready, dout, valid, done
`ifdef SEQ_PATTERN_TX_MARK_EN
    , input mark
`endif
  );

  modport slave (
    input  start, stop, pattern, len, reps, gap,
    output ready, dout, valid, done
`ifdef SEQ_PATTERN_TX_MARK_EN
    , output mark
`endif
  );

endinterface

// File: rtl/seq_shift_core.sv
// rtl/seq_shift_core.sv - MSB-first pattern shifter with remaining-bit counter
module seq_shift_core #(
  parameter int PAT_W = 8,
  parameter int LW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] load_pat,
  input  logic [LW-1:0]    load_len,
  output logic             bit_out,
  output logic             last
);

  localparam logic [LW-1:0] PAT_W_L = LW'(PAT_W);

  logic [PAT_W-1:0] sreg;
  logic [LW-1:0]    cnt;

  // Left-align the active bits so the bit on air is always sreg[PAT_W-1].
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= load_pat << (PAT_W_L - load_len);
      cnt  <= load_len;
    end else if (shift) begin
      sreg <= {sreg[PAT_W-2:0], 1'b0};
      cnt  <= cnt - 1'b1;
    end
  end

  assign bit_out = sreg[PAT_W-1];
  assign last    = (cnt == LW'(1));

endmodule

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - repeating serial pattern transmitter with gap insertion
// SEQ_PATTERN_TX_MARK_EN adds a mark pulse on the last bit of every repetition.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  seq_pattern_tx_if.slave  bus
);

  localparam int            LW      = $clog2(PAT_W + 1);
  localparam logic [LW-1:0] PAT_W_L = LW'(PAT_W);

  seq_state_e       state, state_nx;
  logic [PAT_W-1:0] pat_q, pat_ld;
  logic [LW-1:0]    len_q, len_in, len_ld;
  logic [CNT_W-1:0] gap_q, gap_left, rep_left;
  logic             cont_q;
  logic             accept, load, shift, rep_end, to_gap;
  logic             bit_out, last, final_rep;

  assign len_in    = (bus.len == '0 || bus.len > PAT_W_L) ? PAT_W_L : bus.len;
  assign final_rep = !cont_q && (rep_left == CNT_W'(1));
  assign pat_ld    = accept ? bus.pattern : pat_q;
  assign len_ld    = accept ? len_in : len_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    load     = 1'b0;
    shift    = 1'b0;
    rep_end  = 1'b0;
    to_gap   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          accept   = 1'b1;
          load     = 1'b1;
          state_nx = SEND;
        end
      end
      SEND: begin
        if (bus.stop) begin
          state_nx = IDLE;
        end else if (last) begin
          rep_end = 1'b1;
          if (final_rep) begin
            state_nx = IDLE;
          end else begin
            // Reload now so the next repetition is ready whether or not a gap follows.
            load = 1'b1;
            if (gap_q != '0) begin
              to_gap   = 1'b1;
              state_nx = GAP;
            end
          end
        end else begin
          shift = 1'b1;
        end
      end
      GAP: begin
        if (bus.stop)                      state_nx = IDLE;
        else if (gap_left == CNT_W'(1))    state_nx = SEND;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q    <= '0;
      len_q    <= '0;
      gap_q    <= '0;
      rep_left <= '0;
      cont_q   <= 1'b0;
      gap_left <= '0;
    end else begin
      if (accept) begin
        pat_q    <= bus.pattern;
        len_q    <= len_in;
        gap_q    <= bus.gap;
        rep_left <= bus.reps;
        cont_q   <= (bus.reps == '0);
      end
      if (rep_end && !cont_q) rep_left <= rep_left - 1'b1;
      if (to_gap)             gap_left <= gap_q;
      else if (state == GAP)  gap_left <= gap_left - 1'b1;
    end
  end

  seq_shift_core #(.PAT_W(PAT_W), .LW(LW)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .shift    (shift),
    .load_pat (pat_ld),
    .load_len (len_ld),
    .bit_out  (bit_out),
    .last     (last)
  );

  assign bus.ready = (state == IDLE);
  assign bus.valid = (state == SEND);
  assign bus.dout  = bus.valid & bit_out;
  assign bus.done  = bus.valid & last & final_rep;
`ifdef SEQ_PATTERN_TX_MARK_EN
  assign bus.mark  = bus.valid & last;
`endif

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - directed-vector bench for seq_pattern_tx
module tb_seq_pattern_tx;
  import seq_pkg::*;

  localparam int PAT_W = PAT_W_DEF;
  localparam int CNT_W = CNT_W_DEF;
  localparam int LW    = $clog2(PAT_W + 1);

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  seq_pattern_tx_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

  seq_pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] cv, cd, cn, cr, cm;
  logic [3:0]  det_sh;
  int          det_cnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b expected %0b", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the request is sampled at the next rising edge.
  task automatic start_tx(input string tag, input logic [7:0] pat, input logic [LW-1:0] ln,
                          input logic [CNT_W-1:0] rp, input logic [CNT_W-1:0] gp);
    check_eq({tag, "_ready"}, 32'(bus.ready), 32'd1);
    bus.start   = 1'b1;
    bus.stop    = 1'b0;
    bus.pattern = pat;
    bus.len     = ln;
    bus.reps    = rp;
    bus.gap     = gp;
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  // Samples n cycles (cycle 1 = first after acceptance), oldest cycle in the MSB.
  task automatic capture(input int n, input int stop_at, input int junk_at);
    cv = '0; cd = '0; cn = '0; cr = '0; cm = '0;
    det_sh = '0; det_cnt = 0;
    for (int i = 1; i <= n; i++) begin
      cv = {cv[30:0], bus.valid};
      cd = {cd[30:0], bus.dout};
      cn = {cn[30:0], bus.done};
      cr = {cr[30:0], bus.ready};
`ifdef SEQ_PATTERN_TX_MARK_EN
      cm = {cm[30:0], bus.mark};
`endif
      det_sh = {det_sh[2:0], bus.dout};
      if (det_sh == 4'b1010) det_cnt++;
      bus.stop = (i == stop_at);
      if (i == junk_at) begin
        bus.start   = 1'b1;
        bus.pattern = 8'hFF;
        bus.len     = LW'(3);
        bus.reps    = CNT_W'(5);
        bus.gap     = '0;
      end else begin
        bus.start = 1'b0;
      end
      if (i < n) @(negedge clk);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.pattern = '0;
    bus.len = '0; bus.reps = '0; bus.gap = '0;

    @(negedge clk);
    bus.start = 1'b1; bus.pattern = 8'hFF; bus.len = LW'(8); bus.reps = CNT_W'(1);
    @(negedge clk);
    check_eq("rst_ready", 32'(bus.ready), 32'd1);
    check_eq("rst_valid", 32'(bus.valid), 32'd0);
    check_eq("rst_dout",  32'(bus.dout),  32'd0);
    check_eq("rst_done",  32'(bus.done),  32'd0);
    bus.start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_eq("post_rst_valid", 32'(bus.valid), 32'd0);

    // single 4-bit repetition, then back-to-back start when ready returns
    start_tx("t1", 8'h0A, LW'(4), CNT_W'(1), CNT_W'(0));
    capture(5, 0, 0);
    check_eq("t1_valid", cv, 32'b11110);
    check_eq("t1_dout",  cd, 32'b10100);
    check_eq("t1_done",  cn, 32'b00010);
    check_eq("t1_ready", cr, 32'b00001);
    start_tx("b2b", 8'h03, LW'(2), CNT_W'(1), CNT_W'(0));
    capture(3, 0, 0);
    check_eq("b2b_valid", cv, 32'b110);
    check_eq("b2b_dout",  cd, 32'b110);
    check_eq("b2b_done",  cn, 32'b010);

    // two repetitions with a 2-cycle gap; a stray start mid-send must be ignored
    start_tx("t2", 8'h0A, LW'(4), CNT_W'(2), CNT_W'(2));
    capture(11, 0, 2);
    check_eq("t2_valid", cv, 32'b11110011110);
    check_eq("t2_dout",  cd, 32'b10100010100);
    check_eq("t2_done",  cn, 32'b00000000010);
    check_eq("t2_ready", cr, 32'b00000000001);
`ifdef SEQ_PATTERN_TX_MARK_EN
    check_eq("t2_mark",  cm, 32'b00010000010);
`endif

    // len=0 means full width
    start_tx("t3", 8'hA5, LW'(0), CNT_W'(1), CNT_W'(0));
    capture(9, 0, 0);
    check_eq("t3_valid", cv, 32'b111111110);
    check_eq("t3_dout",  cd, 32'b101001010);
    check_eq("t3_done",  cn, 32'b000000010);

    // len above PAT_W clamps to PAT_W
    start_tx("t3b", 8'hC3, LW'(12), CNT_W'(1), CNT_W'(0));
    capture(9, 0, 0);
    check_eq("t3b_valid", cv, 32'b111111110);
    check_eq("t3b_dout",  cd, 32'b110000110);
    check_eq("t3b_done",  cn, 32'b000000010);

    // continuous mode, stop after the tenth valid bit
    start_tx("t4", 8'h0A, LW'(4), CNT_W'(0), CNT_W'(0));
    capture(11, 10, 0);
    check_eq("t4_valid", cv, 32'b11111111110);
    check_eq("t4_dout",  cd, 32'b10101010100);
    check_eq("t4_done",  cn, 32'b00000000000);
    check_eq("t4_ready", cr, 32'b00000000001);
`ifdef SEQ_PATTERN_TX_MARK_EN
    check_eq("t4_mark",  cm, 32'b00010001000);
`endif

    // stop wins over start in IDLE
    bus.start = 1'b1; bus.stop = 1'b1;
    bus.pattern = 8'h0A; bus.len = LW'(4); bus.reps = CNT_W'(1); bus.gap = '0;
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0;
    check_eq("t5_valid", 32'(bus.valid), 32'd0);
    check_eq("t5_ready", 32'(bus.ready), 32'd1);
    @(negedge clk);
    check_eq("t5_valid2", 32'(bus.valid), 32'd0);

    // asynchronous reset in the middle of a repetition
    start_tx("t6", 8'hFF, LW'(8), CNT_W'(1), CNT_W'(0));
    capture(3, 0, 0);
    check_eq("t6_pre_valid", cv, 32'b111);
    #2 reset = 1'b0;
    #1;
    check_eq("t6_rst_dout",  32'(bus.dout),  32'd0);
    check_eq("t6_rst_valid", 32'(bus.valid), 32'd0);
    check_eq("t6_rst_ready", 32'(bus.ready), 32'd1);
    check_eq("t6_rst_done",  32'(bus.done),  32'd0);
    @(negedge clk);
    reset = 1'b1;
    start_tx("t6b", 8'h0A, LW'(4), CNT_W'(1), CNT_W'(0));
    capture(5, 0, 0);
    check_eq("t6b_valid", cv, 32'b11110);
    check_eq("t6b_dout",  cd, 32'b10100);
    check_eq("t6b_done",  cn, 32'b00010);

    // loopback into a 1010 detector, three repetitions with a 1-cycle gap
    start_tx("t7", 8'h0A, LW'(4), CNT_W'(3), CNT_W'(1));
    capture(15, 0, 5);
    check_eq("t7_valid", cv, 32'b111101111011110);
    check_eq("t7_done",  cn, 32'b000000000000010);
    check_eq("t7_detect", 32'(det_cnt), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
